seg14_scroll_ctrl: RTL and testbench

Sequencer for the 12-digit, 14-segment multiplexed display: holds a host-writable message buffer of character codes and time-multiplexes it onto the one-hot digit select and segment outputs. Supports static text and right-to-left scrolling. It replaces the fixed-text scan used for the banner and sits directly between the user-project logic and the display pads.

---
 rtl/seg14_scroll_if.sv | 26 ++
 rtl/seg14_scroll_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_seg14_scroll_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg14_scroll_if.sv
// Host-side control/write bus and display outputs of the 14-segment scroll sequencer.
interface seg14_scroll_if #(
    parameter int unsigned NUM_DIGITS = 12
);
    logic                  wr_en;
    logic [4:0]            wr_addr;
    logic [5:0]            wr_char;
    logic [5:0]            msg_len;
    logic                  scroll;
    logic                  start;
    logic                  stop;
    logic [NUM_DIGITS-1:0] sel;
    logic [13:0]           segm;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output wr_en, wr_addr, wr_char, msg_len, scroll, start, stop,
        input  sel, segm, busy, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_char, msg_len, scroll, start, stop,
        output sel, segm, busy, frame_done
    );
endinterface

// File: rtl/seg14_scroll_ctrl.sv
// Multiplexed 14-segment display sequencer: message buffer, digit scan, optional
// right-to-left scrolling and font lookup, with sel/segm registered together.
module seg14_scroll_ctrl #(
    parameter int unsigned NUM_DIGITS    = 12,
    parameter int unsigned MSG_LEN       = 32,
    parameter int unsigned DIGIT_TICKS   = 1,
    parameter int unsigned SCROLL_FRAMES = 4
) (
`ifdef USE_POWER_PINS
    inout wire             vdd,
    inout wire             vss,
`endif
    input  logic           clk,
    input  logic           rst,
    seg14_scroll_if.slave  bus_if
);

    localparam int unsigned DigitW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DwellW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int unsigned FrameW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam int unsigned AddrW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    localparam logic [DigitW-1:0] DigitLast = DigitW'(NUM_DIGITS - 1);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(DIGIT_TICKS - 1);
    localparam logic [FrameW-1:0] FrameLast = FrameW'(SCROLL_FRAMES - 1);
    localparam logic [5:0]        CharSpace = 6'd37;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e                state_q, state_d;
    logic [5:0]            len_q, len_d;
    logic                  scroll_q, scroll_d;
    logic [DigitW-1:0]     digit_q, digit_d;
    logic [DwellW-1:0]     dwell_q, dwell_d;
    logic [FrameW-1:0]     frame_q, frame_d;
    logic [5:0]            offset_q, offset_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [13:0]           segm_q, segm_d;
    logic                  frame_done_q, frame_done_d;
    logic [5:0]            msg_q [MSG_LEN];

    logic                  active;
    logic [5:0]            len_in;
    logic [6:0]            fetch_sum;
    logic [6:0]            fetch_idx;
    logic [5:0]            char_code;

    function automatic logic [13:0] font(input logic [5:0] code);
        logic [13:0] pat;
        case (code)
            6'd0:    pat = 14'b1111_1100_0010_01;
            6'd1:    pat = 14'b0110_0000_0010_00;
            6'd2:    pat = 14'b1101_1011_0000_00;
            6'd3:    pat = 14'b1111_0001_0000_00;
            6'd4:    pat = 14'b0110_0111_0000_00;
            6'd5:    pat = 14'b1011_0111_0000_00;
            6'd6:    pat = 14'b1011_1111_0000_00;
            6'd7:    pat = 14'b1110_0000_0000_00;
            6'd8:    pat = 14'b1111_1111_0000_00;
            6'd9:    pat = 14'b1111_0111_0000_00;
            6'd10:   pat = 14'b1110_1111_0000_00;  // A
            6'd11:   pat = 14'b1111_0001_0100_10;
            6'd12:   pat = 14'b1001_1100_0000_00;
            6'd13:   pat = 14'b1111_0000_0100_10;
            6'd14:   pat = 14'b1001_1110_0000_00;
            6'd15:   pat = 14'b1000_1110_0000_00;
            6'd16:   pat = 14'b1011_1101_0000_00;  // G
            6'd17:   pat = 14'b0110_1111_0000_00;
            6'd18:   pat = 14'b1001_0000_0100_10;
            6'd19:   pat = 14'b0111_1000_0000_00;
            6'd20:   pat = 14'b0000_1110_0011_00;
            6'd21:   pat = 14'b0001_1100_0000_00;  // L
            6'd22:   pat = 14'b0110_1100_1010_00;
            6'd23:   pat = 14'b0110_1100_1001_00;
            6'd24:   pat = 14'b1111_1100_0000_00;  // O
            6'd25:   pat = 14'b1100_1111_0000_00;
            6'd26:   pat = 14'b1111_1100_0001_00;
            6'd27:   pat = 14'b1100_1111_0001_00;
            6'd28:   pat = 14'b1011_0111_0000_00;
            6'd29:   pat = 14'b1000_0000_0100_10;
            6'd30:   pat = 14'b0111_1100_0000_00;
            6'd31:   pat = 14'b0000_1100_0010_01;
            6'd32:   pat = 14'b0110_1100_0001_01;
            6'd33:   pat = 14'b0000_0000_1011_01;
            6'd34:   pat = 14'b0000_0000_1010_10;
            6'd35:   pat = 14'b1001_0000_0010_01;
            6'd36:   pat = 14'b1110_1100_1001_00;  // N with tilde
            default: pat = 14'b0;                  // space and unassigned codes
        endcase
        return pat;
    endfunction

    assign len_in = (32'(bus_if.msg_len) > MSG_LEN) ? 6'(MSG_LEN) : bus_if.msg_len;

    // Counters describe the digit that will be on the outputs after this edge.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        scroll_d = scroll_q;
        digit_d  = digit_q;
        dwell_d  = dwell_q;
        frame_d  = frame_q;
        offset_d = offset_q;
        active   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_if.start && !bus_if.stop) begin
                    state_d  = StRun;
                    len_d    = len_in;
                    scroll_d = bus_if.scroll;
                    digit_d  = '0;
                    dwell_d  = '0;
                    frame_d  = '0;
                    offset_d = '0;
                    active   = 1'b1;
                end
            end
            StRun: begin
                if (bus_if.stop) begin
                    state_d  = StIdle;
                    digit_d  = '0;
                    dwell_d  = '0;
                    frame_d  = '0;
                    offset_d = '0;
                end else begin
                    active = 1'b1;
                    if (dwell_q == DwellLast) begin
                        dwell_d = '0;
                        if (digit_q == DigitLast) begin
                            digit_d = '0;
                            if (frame_q == FrameLast) begin
                                frame_d = '0;
                                if (scroll_q && (len_q != 6'd0)) begin
                                    offset_d = (offset_q == len_q - 6'd1) ? 6'd0
                                                                          : offset_q + 6'd1;
                                end
                            end else begin
                                frame_d = frame_q + FrameW'(1);
                            end
                        end else begin
                            digit_d = digit_q + DigitW'(1);
                        end
                    end else begin
                        dwell_d = dwell_q + DwellW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fetch_sum = 7'(offset_d) + 7'(digit_d);
        fetch_idx = '0;
        char_code = CharSpace;
        if (len_d != 6'd0) begin
            fetch_idx = scroll_d ? (fetch_sum % 7'(len_d)) : 7'(digit_d);
            if (scroll_d || (7'(digit_d) < 7'(len_d))) begin
                char_code = msg_q[AddrW'(fetch_idx)];
            end
        end
    end

    always_comb begin
        sel_d        = '0;
        segm_d       = '0;
        frame_done_d = 1'b0;
        if (active) begin
            sel_d        = NUM_DIGITS'(1) << digit_d;
            segm_d       = font(char_code);
            frame_done_d = (digit_d == DigitLast) && (dwell_d == DwellLast);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            len_q        <= '0;
            scroll_q     <= 1'b0;
            digit_q      <= '0;
            dwell_q      <= '0;
            frame_q      <= '0;
            offset_q     <= '0;
            sel_q        <= '0;
            segm_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            scroll_q     <= scroll_d;
            digit_q      <= digit_d;
            dwell_q      <= dwell_d;
            frame_q      <= frame_d;
            offset_q     <= offset_d;
            sel_q        <= sel_d;
            segm_q       <= segm_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Reset has priority, so a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                msg_q[AddrW'(i)] <= CharSpace;
            end
        end else if (bus_if.wr_en && (32'(bus_if.wr_addr) < MSG_LEN)) begin
            msg_q[AddrW'(bus_if.wr_addr)] <= bus_if.wr_char;
        end
    end

    assign bus_if.sel        = sel_q;
    assign bus_if.segm       = segm_q;
    assign bus_if.busy       = (state_q == StRun);
    assign bus_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg14_scroll_ctrl.sv
// Self-checking bench: directed steps plus random traffic against a time-based reference model.
module tb_seg14_scroll_ctrl;

    localparam int ND = 12;
    localparam int ML = 24;
    localparam int DT = 2;
    localparam int SF = 2;
    localparam int FRAME_CYC = ND * DT;

    localparam logic [13:0] PAT_A = 14'b11101111000000;
    localparam logic [13:0] PAT_G = 14'b10111101000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg14_scroll_if #(.NUM_DIGITS(ND)) host_bus ();

    seg14_scroll_ctrl #(
        .NUM_DIGITS    (ND),
        .MSG_LEN       (ML),
        .DIGIT_TICKS   (DT),
        .SCROLL_FRAMES (SF)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (host_bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: cycles since start plus a copy of the buffer.
    bit          m_run;
    int          m_t;
    int          m_len;
    bit          m_scr;
    logic [5:0]  m_msg [ML];
    logic [ND-1:0] exp_sel;
    logic [13:0] exp_segm;
    logic        exp_busy;
    logic        exp_fd;

    function automatic logic [13:0] ref_font(input int code);
        case (code)
            0:       return 14'b11111100001001;
            10:      return 14'b11101111000000;
            14:      return 14'b10011110000000;
            16:      return 14'b10111101000000;
            21:      return 14'b00011100000000;
            24:      return 14'b11111100000000;
            28:      return 14'b10110111000000;
            default: return 14'b0;
        endcase
    endfunction

    function automatic logic [5:0] rand_code();
        int unsigned r = $urandom_range(0, 9);
        case (r)
            0:       return 6'd0;
            1:       return 6'd10;
            2:       return 6'd14;
            3:       return 6'd16;
            4:       return 6'd21;
            5:       return 6'd24;
            6:       return 6'd28;
            7:       return 6'd37;
            default: return 6'(38 + $urandom_range(0, 25));
        endcase
    endfunction

    task automatic model_edge();
        int d, fr, off, code;
        if (rst) begin
            m_run = 1'b0;
            m_t   = 0;
            for (int i = 0; i < ML; i++) m_msg[i] = 6'd37;
        end else begin
            if (!m_run) begin
                if (host_bus.start && !host_bus.stop) begin
                    m_run = 1'b1;
                    m_t   = 0;
                    m_len = (int'(host_bus.msg_len) > ML) ? ML : int'(host_bus.msg_len);
                    m_scr = host_bus.scroll;
                end
            end else if (host_bus.stop) begin
                m_run = 1'b0;
            end else begin
                m_t++;
            end
        end
        exp_sel  = '0;
        exp_segm = '0;
        exp_busy = m_run;
        exp_fd   = 1'b0;
        if (m_run) begin
            d   = (m_t / DT) % ND;
            fr  = m_t / FRAME_CYC;
            off = (m_scr && m_len > 0) ? (fr / SF) % m_len : 0;
            if (m_len == 0)      code = 37;
            else if (m_scr)      code = int'(m_msg[(off + d) % m_len]);
            else if (d < m_len)  code = int'(m_msg[d]);
            else                 code = 37;
            exp_sel[d] = 1'b1;
            exp_segm   = ref_font(code);
            exp_fd     = ((m_t % FRAME_CYC) == FRAME_CYC - 1);
        end
        // Buffer update lands after this edge's fetch.
        if (!rst && host_bus.wr_en && (int'(host_bus.wr_addr) < ML))
            m_msg[host_bus.wr_addr] = host_bus.wr_char;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("sel", 32'(host_bus.sel), 32'(exp_sel));
        chk("segm", 32'(host_bus.segm), 32'(exp_segm));
        chk("busy", 32'(host_bus.busy), 32'(exp_busy));
        chk("frame_done", 32'(host_bus.frame_done), 32'(exp_fd));
    endtask

    task automatic wr(input int addr, input logic [5:0] code);
        host_bus.wr_en   = 1'b1;
        host_bus.wr_addr = 5'(addr);
        host_bus.wr_char = code;
        tick();
        host_bus.wr_en = 1'b0;
    endtask

    task automatic begin_run(input int len, input bit scr);
        host_bus.msg_len = 6'(len);
        host_bus.scroll  = scr;
        host_bus.start   = 1'b1;
        tick();
        host_bus.start = 1'b0;
    endtask

    task automatic end_run();
        host_bus.stop = 1'b1;
        tick();
        host_bus.stop = 1'b0;
        chk("stop_busy", 32'(host_bus.busy), 32'd0);
    endtask

    initial begin
        logic [5:0] banner [12];
        int n;
        banner = '{6'd16, 6'd10, 6'd21, 6'd21, 6'd14, 6'd16, 6'd24, 6'd28,
                   6'd0, 6'd0, 6'd0, 6'd0};
        rst = 1'b1;
        host_bus.wr_en   = 1'b0;
        host_bus.wr_addr = '0;
        host_bus.wr_char = '0;
        host_bus.msg_len = '0;
        host_bus.scroll  = 1'b0;
        host_bus.start   = 1'b0;
        host_bus.stop    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_sel", 32'(host_bus.sel), 32'd0);

        // Static banner.
        for (int i = 0; i < 12; i++) wr(i, banner[i]);
        begin_run(12, 1'b0);
        chk("first_sel", 32'(host_bus.sel), 32'h001);
        chk("first_segm", 32'(host_bus.segm), 32'(PAT_G));
        repeat (2 * FRAME_CYC) tick();
        end_run();

        // Short static message.
        wr(0, 6'd10);
        wr(1, 6'd24);
        wr(2, 6'd0);
        begin_run(3, 1'b0);
        chk("short_segm0", 32'(host_bus.segm), 32'(PAT_A));
        repeat (FRAME_CYC + 5) tick();
        end_run();

        // start+stop together in IDLE stays idle.
        host_bus.start = 1'b1;
        host_bus.stop  = 1'b1;
        tick();
        host_bus.start = 1'b0;
        host_bus.stop  = 1'b0;
        chk("startstop_busy", 32'(host_bus.busy), 32'd0);
        chk("startstop_sel", 32'(host_bus.sel), 32'd0);

        // Scroll over a 13-character message, full offset period and then some.
        for (int i = 0; i < ML; i++) wr(i, rand_code());
        begin_run(13, 1'b1);
        repeat (27 * FRAME_CYC + 7) tick();
        end_run();
        chk("stop_segm", 32'(host_bus.segm), 32'd0);

        // Live write to the digit being displayed, and an out-of-range write.
        for (int i = 0; i < 12; i++) wr(i, 6'd10);
        begin_run(12, 1'b0);
        n = 0;
        while (exp_sel != 12'h020 && n < 100) begin
            tick();
            n++;
        end
        chk("live_sync", 32'(n < 100), 32'd1);
        wr(5, 6'd24);
        wr(29, 6'd16);
        repeat (2 * FRAME_CYC) tick();

        // Reset mid-run, with a write that must be dropped.
        rst = 1'b1;
        host_bus.wr_en   = 1'b1;
        host_bus.wr_addr = 5'd0;
        host_bus.wr_char = 6'd10;
        tick();
        rst = 1'b0;
        host_bus.wr_en = 1'b0;
        chk("rst_busy", 32'(host_bus.busy), 32'd0);
        chk("rst_segm", 32'(host_bus.segm), 32'd0);
        begin_run(12, 1'b0);
        repeat (FRAME_CYC) tick();
        end_run();

        // Random traffic including len 0, len 1, clamped length, live writes, stray starts.
        for (int it = 0; it < 8; it++) begin
            int len;
            bit scr;
            for (int a = 0; a < ML; a++) wr(a, rand_code());
            case (it)
                0:       begin len = 0;  scr = 1'b1; end
                1:       begin len = 1;  scr = 1'b1; end
                2:       begin len = 40; scr = 1'b1; end
                3:       begin len = 24; scr = 1'b0; end
                4:       begin len = 0;  scr = 1'b0; end
                default: begin len = int'($urandom_range(1, 30)); scr = 1'($urandom_range(0, 1)); end
            endcase
            begin_run(len, scr);
            repeat ($urandom_range(60, 200)) begin
                if ($urandom_range(0, 7) == 0) begin
                    host_bus.wr_en   = 1'b1;
                    host_bus.wr_addr = 5'($urandom_range(0, 31));
                    host_bus.wr_char = rand_code();
                end else begin
                    host_bus.wr_en = 1'b0;
                end
                host_bus.start = ($urandom_range(0, 15) == 0);
                tick();
            end
            host_bus.wr_en = 1'b0;
            host_bus.start = 1'b0;
            end_run();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
